// File: rtl/universal_shift_reg_if.sv
// universal_shift_reg_if
// Groups the shift register's control inputs and observable outputs into one bundle.
// The clock and reset are not part of the bundle.
//
// Parameters:
//   WIDTH       register width in bits (legal >= 2)
//
// Signals (direction as seen from the slave, i.e. the shift register):
//   en          in   1      clock enable
//   mode        in   3      operation select
//   serial_in   in   1      bit shifted into the vacated end
//   par_in      in   WIDTH  parallel load data
//   shreg_out   out  WIDTH  current shift register contents
//   serial_out  out  1      bit about to leave the register
//   data_out    out  WIDTH  last completed or loaded word
//   word_valid  out  1      one-cycle pulse after data_out updates
//   bit_cnt     out  CNT_W  serial shifts accumulated toward the current word
//   parity_out  out  1      ^data_out (only when USR_PARITY_EN is defined)
//
// Optional feature macro: USR_PARITY_EN

interface universal_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             en;
    logic [2:0]       mode;
    logic             serial_in;
    logic [WIDTH-1:0] par_in;
    logic [WIDTH-1:0] shreg_out;
    logic             serial_out;
    logic [WIDTH-1:0] data_out;
    logic             word_valid;
    logic [CNT_W-1:0] bit_cnt;
`ifdef USR_PARITY_EN
    logic             parity_out;
`endif

    // Driver side: the board switches / testbench.
    modport master (
        output en,
        output mode,
        output serial_in,
        output par_in,
`ifdef USR_PARITY_EN
        input  parity_out,
`endif
        input  shreg_out,
        input  serial_out,
        input  data_out,
        input  word_valid,
        input  bit_cnt
    );

    // Register side.
    modport slave (
        input  en,
        input  mode,
        input  serial_in,
        input  par_in,
`ifdef USR_PARITY_EN
        output parity_out,
`endif
        output shreg_out,
        output serial_out,
        output data_out,
        output word_valid,
        output bit_cnt
    );
endinterface

// File: rtl/universal_shift_reg.sv
// universal_shift_reg
// WIDTH-bit universal shift register with hold, shift left/right, rotate
// left/right, parallel load and clear. A word-assembly counter tracks serial
// shifts; when WIDTH of them have accumulated, the completed word is latched
// into data_out and word_valid pulses for one cycle. A parallel load also
// latches data_out and pulses word_valid.
//
// Ports:
//   clk_2   in  1  system clock, rising edge
//   reset   in  1  asynchronous, active-high reset
//   bus     universal_shift_reg_if.slave (en, mode, serial_in, par_in,
//           shreg_out, serial_out, data_out, word_valid, bit_cnt,
//           parity_out when enabled)
//
// Optional feature macro: USR_PARITY_EN adds a registered parity_out equal
// to ^data_out, updated on the same edge as data_out.

module universal_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic                  clk_2,
    input  logic                  reset,
    universal_shift_reg_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_ROL   = 3'b011,
        MODE_ROR   = 3'b100,
        MODE_LOAD  = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111
    } mode_e;

    mode_e            op;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             valid_q;
    logic             valid_nxt;
    logic             shift_evt;

    assign op = mode_e'(bus.mode);

    // Next-state selection for the register, the word counter and the
    // completed-word latch. Shifts count toward a word regardless of direction;
    // rotates do not, since no new serial bit enters.
    always_comb begin
        shreg_nxt = shreg;
        data_nxt  = data_q;
        cnt_nxt   = cnt;
        valid_nxt = 1'b0;
        shift_evt = 1'b0;

        unique case (op)
            MODE_SHL: begin
                shreg_nxt = {shreg[WIDTH-2:0], bus.serial_in};
                shift_evt = 1'b1;
            end
            MODE_SHR: begin
                shreg_nxt = {bus.serial_in, shreg[WIDTH-1:1]};
                shift_evt = 1'b1;
            end
            MODE_ROL:   shreg_nxt = {shreg[WIDTH-2:0], shreg[WIDTH-1]};
            MODE_ROR:   shreg_nxt = {shreg[0], shreg[WIDTH-1:1]};
            MODE_LOAD: begin
                shreg_nxt = bus.par_in;
                data_nxt  = bus.par_in;
                cnt_nxt   = '0;
                valid_nxt = 1'b1;
            end
            MODE_CLEAR: begin
                shreg_nxt = '0;
                data_nxt  = '0;
                cnt_nxt   = '0;
            end
            MODE_HOLD, MODE_RSVD: ;
            default: ;
        endcase

        // The shift that brings the count to WIDTH completes the word: the
        // freshly shifted value (not the old one) is what gets latched.
        if (shift_evt) begin
            if (cnt == CNT_W'(WIDTH - 1)) begin
                cnt_nxt   = '0;
                data_nxt  = shreg_nxt;
                valid_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // State register. word_valid is cleared on every edge, even when en=0,
    // so the pulse is exactly one cycle wide; everything else only moves
    // when enabled.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            shreg   <= '0;
            data_q  <= '0;
            cnt     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.en) begin
                shreg   <= shreg_nxt;
                data_q  <= data_nxt;
                cnt     <= cnt_nxt;
                valid_q <= valid_nxt;
            end
        end
    end

`ifdef USR_PARITY_EN
    logic parity_q;

    // Parity follows data_out edge for edge, so it is valid alongside word_valid.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (bus.en) begin
            parity_q <= ^data_nxt;
        end
    end

    assign bus.parity_out = parity_q;
`endif

    // The outgoing bit depends on which end a left-moving mode pushes out.
    assign bus.serial_out = (op == MODE_SHL || op == MODE_ROL) ? shreg[WIDTH-1] : shreg[0];

    assign bus.shreg_out  = shreg;
    assign bus.data_out   = data_q;
    assign bus.word_valid = valid_q;
    assign bus.bit_cnt    = cnt;

endmodule
